sdram_byte_client: RTL and testbench
====================================

// Module: sdram_byte_client
// PURPOSE
//  Initiator for one toggle-handshake SDRAM port (req/ack/we/a/ds/d/q), the requester side of the dual-port SDRAM controller.
//  Converts a byte-wide strobe bus (CPU, ioctl downloader) into 16-bit port accesses.
//  Posts writes through a small FIFO and keeps reads ordered behind all queued writes, so a read always returns data written earlier.
// PARAMETERS
//  AW           24  byte address width; port address is a[AW-1:1]
//  WFIFO_DEPTH   4  posted-write entries, power of 2, range 2..16
// PORTS
//  clk          in   1       system clock, same clock as the SDRAM controller
//  init_n       in   1       asynchronous active-low reset
//  cpu_a        in   AW      byte address, sampled with cpu_rd/cpu_wr
//  cpu_d        in   8       write data, sampled with cpu_wr
//  cpu_wr       in   1       1-cycle write strobe
//  cpu_rd       in   1       1-cycle read strobe
//  cpu_q        out  8       read data, valid while cpu_valid=1 and held until the next read completes
//  cpu_valid    out  1       1-cycle pulse: read data ready
//  cpu_busy     out  1       strobes are not accepted while high
//  wfifo_empty  out  1       no queued write and no write in flight
//  err_drop     out  1       sticky flag: a strobe arrived while cpu_busy=1
//  port_req     out  1       toggle request
//  port_ack     in   1       equals port_req when the access is done
//  port_we      out  1       1=write, 0=read
//  port_a       out  AW-1    word address, cpu_a[AW-1:1]
//  port_ds      out  2       byte enables {upper,lower}
//  port_d       out  16      write data
//  port_q       in   16      read data, valid in the cycle port_ack becomes equal to port_req
// BEHAVIOUR
//  Reset (init_n=0, async): port_req/port_we=0, port_a/port_ds/port_d=0, cpu_q=8'h00, cpu_valid=0,
//   cpu_busy=1, wfifo_empty=1, err_drop=0, FIFO empty, read-pending cleared, state=S_SYNC.
//  Toggle protocol:
//   - Issue a request only when port_req==port_ack, by inverting port_req in the same clock edge that loads we/a/ds/d.
//   - Hold we/a/ds/d stable until port_ack==port_req.
//   - Completion is the first cycle in which port_ack==port_req. For reads, capture port_q in that same cycle, because the controller presents q combinationally only then.
//  Byte lanes:
//   - cpu_a[0]=1 selects the upper byte: ds=2'b10, cpu_q<=port_q[15:8].
//   - cpu_a[0]=0 selects the lower byte: ds=2'b01, cpu_q<=port_q[7:0].
//   - port_d={cpu_d,cpu_d}.
//  FSM:
//   - S_SYNC: lasts 1 cycle after reset release; port_req<=port_ack to adopt the controller's ack phase; go to S_IDLE.
//   - S_IDLE: if the FIFO is not empty, issue the head write -> S_WAIT_W; else if a read is pending, issue the read -> S_WAIT_R.
//   - S_WAIT_W: on completion, pop the FIFO -> S_IDLE.
//   - S_WAIT_R: on completion, load cpu_q, pulse cpu_valid, clear read-pending -> S_IDLE.
//  Acceptance (registered, while cpu_busy=0):
//   - cpu_wr pushes {cpu_a,cpu_d}.
//   - cpu_rd latches cpu_a and sets read-pending.
//   - cpu_rd and cpu_wr in the same cycle: accept both; the write is queued first, so the read returns the new byte when addresses match.
//  cpu_busy = (state==S_SYNC) | FIFO full | read-pending. Registered: it goes high in the cycle after an accepting strobe.
//  A strobe while cpu_busy=1 is dropped (no FIFO or read change) and sets err_drop; err_drop clears only by reset.
//  A write strobe that fills the last entry is accepted; busy then rises.
//  FIFO pointers wrap mod WFIFO_DEPTH and use an extra MSB for full/empty.
//  A pop and a push in the same cycle keep the level unchanged.
//  wfifo_empty = FIFO empty & state!=S_WAIT_W.
//  Minimum latency:
//   - rd strobe -> request issued: 1 cycle.
//   - completion -> cpu_valid: 0 cycles (same edge that captures port_q).
//  Reset mid-access: outstanding access abandoned, queue discarded, S_SYNC re-adopts ack phase; no spurious cpu_valid.
// TESTING
//  T1 write a=24'h000101, d=8'hA5; model acks after 6 clk ->
//     port_we=1, port_a=23'h000080, ds=2'b10, port_d=16'hA5A5, exactly one req toggle.
//  T2 read a=24'h000100, model q=16'h1234 -> cpu_q=8'h34 with 1-cycle cpu_valid; a=24'h000101 -> cpu_q=8'h12.
//  T3 5 back-to-back writes with ack held off (DEPTH=4) -> busy after 4th, 5th dropped, err_drop=1, 4 ordered accesses after ack.
//  T4 cpu_wr and cpu_rd same cycle, a=24'h000010, d=8'h5C -> write issued before read, cpu_q=8'h5C.
//  T5 release reset with port_ack=1 -> first request drives port_req 1->0; no request in S_SYNC cycle.
//  T6 assert init_n=0 during S_WAIT_R -> all outputs at reset values, no cpu_valid, next read completes normally.

Source files
------------

// File: rtl/sdram_byte_client_if.sv
// Toggle-handshake SDRAM port between a byte client (master) and the dual-port SDRAM controller (slave).
// A request is a toggle of req; the access is complete once ack equals req again.
interface sdram_byte_client_if #(
   parameter int AW = 24
);
   logic          req;
   logic          ack;
   logic          we;
   logic [AW-2:0] a;
   logic [1:0]    ds;
   logic [15:0]   d;
   logic [15:0]   q;

   modport master (output req, we, a, ds, d, input ack, q);
   modport slave  (input req, we, a, ds, d, output ack, q);
endinterface

// File: rtl/sdram_byte_client.sv
// Byte-strobe client for one toggle-handshake SDRAM port: posts writes through a small FIFO
// and issues a read only after every earlier write has completed, so reads see prior writes.
module sdram_byte_client #(
   parameter int AW          = 24,
   parameter int WFIFO_DEPTH = 4
) (
   input  logic          clk,
   input  logic          init_n,
   input  logic [AW-1:0] cpu_a,
   input  logic [7:0]    cpu_d,
   input  logic          cpu_wr,
   input  logic          cpu_rd,
   output logic [7:0]    cpu_q,
   output logic          cpu_valid,
   output logic          cpu_busy,
   output logic          wfifo_empty,
   output logic          err_drop,
   sdram_byte_client_if.master port
);

   localparam int PW = $clog2(WFIFO_DEPTH);
   localparam logic [PW:0] FULL_LEVEL = (PW+1)'(WFIFO_DEPTH);

   localparam logic [1:0] S_SYNC   = 2'd0;
   localparam logic [1:0] S_IDLE   = 2'd1;
   localparam logic [1:0] S_WAIT_W = 2'd2;
   localparam logic [1:0] S_WAIT_R = 2'd3;

   logic [1:0]    state;
   logic [1:0]    state_nx;
   logic [AW-1:0] fifo_a [WFIFO_DEPTH];
   logic [7:0]    fifo_d [WFIFO_DEPTH];
   logic [PW:0]   wr_ptr;
   logic [PW:0]   rd_ptr;
   logic [PW:0]   wr_ptr_nx;
   logic [PW:0]   rd_ptr_nx;
   logic [PW:0]   level_nx;
   logic          rd_pend;
   logic          rd_pend_nx;
   logic [AW-1:0] rd_addr;
   logic [AW-1:0] head_a;
   logic [7:0]    head_d;
   logic          fifo_empty;
   logic          port_idle;
   logic          accept_wr;
   logic          accept_rd;
   logic          issue_w;
   logic          issue_r;
   logic          wr_done;
   logic          rd_done;
   logic          busy_nx;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign head_a     = fifo_a[rd_ptr[PW-1:0]];
   assign head_d     = fifo_d[rd_ptr[PW-1:0]];
   assign port_idle  = (port.ack == port.req);

   assign accept_wr = cpu_wr & ~cpu_busy;
   assign accept_rd = cpu_rd & ~cpu_busy;

   // Queued writes always go first, which is what keeps a read behind every earlier write.
   assign issue_w = (state == S_IDLE) && port_idle && !fifo_empty;
   assign issue_r = (state == S_IDLE) && port_idle && fifo_empty && rd_pend;
   assign wr_done = (state == S_WAIT_W) && port_idle;
   assign rd_done = (state == S_WAIT_R) && port_idle;

   assign wr_ptr_nx  = wr_ptr + {{PW{1'b0}}, accept_wr};
   assign rd_ptr_nx  = rd_ptr + {{PW{1'b0}}, wr_done};
   assign level_nx   = wr_ptr_nx - rd_ptr_nx;
   assign rd_pend_nx = accept_rd | (rd_pend & ~rd_done);
   assign busy_nx    = (state_nx == S_SYNC) | (level_nx == FULL_LEVEL) | rd_pend_nx;

   assign wfifo_empty = fifo_empty && (state != S_WAIT_W);

   always_comb begin
      state_nx = state;
      case (state)
         S_SYNC:   state_nx = S_IDLE;
         S_IDLE: begin
            if (issue_w)
               state_nx = S_WAIT_W;
            else if (issue_r)
               state_nx = S_WAIT_R;
         end
         S_WAIT_W: if (wr_done) state_nx = S_IDLE;
         S_WAIT_R: if (rd_done) state_nx = S_IDLE;
         default:  state_nx = S_SYNC;
      endcase
   end

   // Control state, queue pointers and the pending read; busy is registered from next-state values.
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         state    <= S_SYNC;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         rd_pend  <= 1'b0;
         rd_addr  <= '0;
         cpu_busy <= 1'b1;
         err_drop <= 1'b0;
      end else begin
         state    <= state_nx;
         wr_ptr   <= wr_ptr_nx;
         rd_ptr   <= rd_ptr_nx;
         rd_pend  <= rd_pend_nx;
         cpu_busy <= busy_nx;
         if (accept_rd)
            rd_addr <= cpu_a;
         if ((cpu_wr | cpu_rd) & cpu_busy)
            err_drop <= 1'b1;
      end
   end

   // Posted-write storage needs no reset; only the pointers say which entries are live.
   always_ff @(posedge clk) begin
      if (accept_wr) begin
         fifo_a[wr_ptr[PW-1:0]] <= cpu_a;
         fifo_d[wr_ptr[PW-1:0]] <= cpu_d;
      end
   end

   // S_SYNC copies ack into req so a restart never looks like a fresh request to the controller.
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         port.req <= 1'b0;
         port.we  <= 1'b0;
         port.a   <= '0;
         port.ds  <= 2'b00;
         port.d   <= 16'h0000;
      end else if (state == S_SYNC) begin
         port.req <= port.ack;
      end else if (issue_w) begin
         port.req <= ~port.req;
         port.we  <= 1'b1;
         port.a   <= head_a[AW-1:1];
         port.ds  <= head_a[0] ? 2'b10 : 2'b01;
         port.d   <= {head_d, head_d};
      end else if (issue_r) begin
         port.req <= ~port.req;
         port.we  <= 1'b0;
         port.a   <= rd_addr[AW-1:1];
         port.ds  <= rd_addr[0] ? 2'b10 : 2'b01;
      end
   end

   // The controller only drives q in the completion cycle, so it is captured on that very edge.
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         cpu_q     <= 8'h00;
         cpu_valid <= 1'b0;
      end else begin
         cpu_valid <= rd_done;
         if (rd_done)
            cpu_q <= rd_addr[0] ? port.q[15:8] : port.q[7:0];
      end
   end

endmodule

// File: tb/tb_sdram_byte_client.sv
// Self-checking bench for sdram_byte_client: a toggle-protocol SDRAM responder plus a byte-level
// memory model that predicts read data, busy, queue-empty and error flags from accepted strobes.
module tb_sdram_byte_client;

   localparam int AW    = 24;
   localparam int DEPTH = 4;

   logic          clk    = 1'b0;
   logic          init_n = 1'b0;
   logic [AW-1:0] cpu_a  = '0;
   logic [7:0]    cpu_d  = 8'h00;
   logic          cpu_wr = 1'b0;
   logic          cpu_rd = 1'b0;
   logic [7:0]    cpu_q;
   logic          cpu_valid;
   logic          cpu_busy;
   logic          wfifo_empty;
   logic          err_drop;

   sdram_byte_client_if #(.AW(AW)) port_bus ();

   sdram_byte_client #(.AW(AW), .WFIFO_DEPTH(DEPTH)) dut (
      .clk         (clk),
      .init_n      (init_n),
      .cpu_a       (cpu_a),
      .cpu_d       (cpu_d),
      .cpu_wr      (cpu_wr),
      .cpu_rd      (cpu_rd),
      .cpu_q       (cpu_q),
      .cpu_valid   (cpu_valid),
      .cpu_busy    (cpu_busy),
      .wfifo_empty (wfifo_empty),
      .err_drop    (err_drop),
      .port        (port_bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [7:0]    d;
   } wr_t;

   int             n_cmp = 0;
   int             n_fail = 0;
   logic [7:0]     byte_mem [int];
   logic [15:0]    ctrl_mem [int];
   wr_t            exp_wq [$];
   logic [AW-1:0]  exp_ra [$];
   logic [7:0]     exp_rv [$];
   int             wr_out = 0;
   int             rd_out = 0;
   bit             in_sync = 1'b1;
   bit             exp_valid = 1'b0;
   bit             err_exp = 1'b0;
   bit             hold_ack = 1'b0;
   logic [7:0]     exp_q = 8'h00;
   logic [7:0]     last_q = 8'h00;
   int             ack_min = 0;
   int             ack_max = 3;
   int             n_req = 0;
   int             n_wdone = 0;

   bit             rsp_active = 1'b0;
   int             rsp_delay = 0;
   logic           rsp_we;
   logic           rsp_req;
   logic [AW-2:0]  rsp_a;
   logic [1:0]     rsp_ds;
   logic [15:0]    rsp_d;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] rd_byte(input logic [AW-1:0] a);
      return byte_mem.exists(int'(a)) ? byte_mem[int'(a)] : 8'h00;
   endfunction

   function automatic logic [15:0] rd_word(input logic [AW-2:0] w);
      return ctrl_mem.exists(int'(w)) ? ctrl_mem[int'(w)] : 16'h0000;
   endfunction

   function automatic bit exp_busy();
      return in_sync || (wr_out == DEPTH) || (rd_out != 0);
   endfunction

   // The sync cycle ends at the first clock edge seen with reset released.
   initial forever begin
      @(posedge clk);
      if (init_n) in_sync = 1'b0;
   end

   // SDRAM controller model: answers each req toggle after a random delay and applies it to a word memory.
   initial begin
      port_bus.ack = 1'b0;
      port_bus.q   = 16'h0000;
      forever begin
         @(negedge clk);
         #1;
         port_bus.q = 16'($urandom);
         if (!init_n || in_sync) begin
            rsp_active = 1'b0;
            continue;
         end
         if (!rsp_active && (port_bus.req != port_bus.ack)) begin
            rsp_active = 1'b1;
            rsp_we  = port_bus.we;
            rsp_req = port_bus.req;
            rsp_a   = port_bus.a;
            rsp_ds  = port_bus.ds;
            rsp_d   = port_bus.d;
            rsp_delay = $urandom_range(ack_max, ack_min);
            n_req++;
            if (rsp_we) begin
               n_cmp++;
               if (exp_wq.size() == 0) begin
                  n_fail++;
                  $display("[TB] FAIL write_expected: got a write request, expected none queued");
               end else begin
                  check_output("wr_addr", 32'(rsp_a), 32'(exp_wq[0].a >> 1));
                  check_output("wr_ds", 32'(rsp_ds), exp_wq[0].a[0] ? 32'h2 : 32'h1);
                  check_output("wr_data", 32'(rsp_d), {16'h0, exp_wq[0].d, exp_wq[0].d});
               end
            end else begin
               check_output("rd_after_writes", wr_out, 0);
               n_cmp++;
               if (exp_ra.size() == 0) begin
                  n_fail++;
                  $display("[TB] FAIL read_expected: got a read request, expected none pending");
               end else begin
                  check_output("rd_addr", 32'(rsp_a), 32'(exp_ra[0] >> 1));
                  check_output("rd_ds", 32'(rsp_ds), exp_ra[0][0] ? 32'h2 : 32'h1);
               end
            end
         end else if (rsp_active) begin
            check_output("hold_req", port_bus.req, rsp_req);
            check_output("hold_we", port_bus.we, rsp_we);
            check_output("hold_a", 32'(port_bus.a), 32'(rsp_a));
            check_output("hold_ds", 32'(port_bus.ds), 32'(rsp_ds));
            if (rsp_we) check_output("hold_d", 32'(port_bus.d), 32'(rsp_d));
            if (!hold_ack && rsp_delay > 0) rsp_delay--;
         end
         if (rsp_active && !hold_ack && rsp_delay == 0) begin
            if (rsp_we) begin
               logic [15:0] w;
               w = rd_word(rsp_a);
               if (rsp_ds[0]) w[7:0]  = rsp_d[7:0];
               if (rsp_ds[1]) w[15:8] = rsp_d[15:8];
               ctrl_mem[int'(rsp_a)] = w;
            end else begin
               port_bus.q = rd_word(rsp_a);
            end
            port_bus.ack = rsp_req;
            rsp_active = 1'b0;
            @(posedge clk);
            if (rsp_we) begin
               if (exp_wq.size() != 0) void'(exp_wq.pop_front());
               if (wr_out > 0) wr_out--;
               n_wdone++;
            end else if (exp_rv.size() != 0) begin
               exp_q = exp_rv.pop_front();
               void'(exp_ra.pop_front());
               if (rd_out > 0) rd_out--;
               exp_valid = 1'b1;
            end
         end
      end
   end

   // Cycle-by-cycle comparison of the client outputs against the model.
   initial forever begin
      @(negedge clk);
      #3;
      check_output("cpu_busy", cpu_busy, exp_busy());
      check_output("wfifo_empty", wfifo_empty, (wr_out == 0));
      check_output("err_drop", err_drop, err_exp);
      check_output("cpu_valid", cpu_valid, exp_valid);
      if (exp_valid) begin
         last_q = exp_q;
         exp_valid = 1'b0;
      end
      check_output("cpu_q", cpu_q, last_q);
      if (!init_n) begin
         check_output("rst_port_req", port_bus.req, 0);
         check_output("rst_port_we", port_bus.we, 0);
         check_output("rst_port_a", 32'(port_bus.a), 0);
         check_output("rst_port_ds", 32'(port_bus.ds), 0);
         check_output("rst_port_d", 32'(port_bus.d), 0);
      end
   end

   task automatic apply_stimulus(input bit wr, input bit rd, input logic [AW-1:0] a, input logic [7:0] d);
      bit  acc;
      wr_t e;
      @(negedge clk);
      cpu_wr = wr;
      cpu_rd = rd;
      cpu_a  = a;
      cpu_d  = d;
      acc = !exp_busy();
      @(posedge clk);
      if (acc) begin
         if (wr) begin
            byte_mem[int'(a)] = d;
            e.a = a;
            e.d = d;
            exp_wq.push_back(e);
            wr_out++;
         end
         if (rd) begin
            exp_ra.push_back(a);
            exp_rv.push_back(rd_byte(a));
            rd_out++;
         end
      end else if (wr || rd) begin
         err_exp = 1'b1;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         cpu_wr = 1'b0;
         cpu_rd = 1'b0;
         @(posedge clk);
      end
   endtask

   task automatic settle();
      @(negedge clk);
      cpu_wr = 1'b0;
      cpu_rd = 1'b0;
      #4;
   endtask

   task automatic wait_quiet(input int max_cycles);
      int i = 0;
      while ((wr_out != 0 || rd_out != 0) && i < max_cycles) begin
         idle(1);
         i++;
      end
      n_cmp++;
      if (wr_out != 0 || rd_out != 0) begin
         n_fail++;
         $display("[TB] FAIL drain_timeout: %0d writes and %0d reads outstanding, expected 0", wr_out, rd_out);
      end
      idle(1);
   endtask

   task automatic do_reset(input logic ack_val);
      @(negedge clk);
      init_n = 1'b0;
      cpu_wr = 1'b0;
      cpu_rd = 1'b0;
      wr_out = 0;
      rd_out = 0;
      exp_wq.delete();
      exp_ra.delete();
      exp_rv.delete();
      in_sync   = 1'b1;
      exp_valid = 1'b0;
      err_exp   = 1'b0;
      last_q    = 8'h00;
      hold_ack  = 1'b0;
      port_bus.ack = ack_val;
      #4;
      check_output("rst_cpu_busy", cpu_busy, 1);
      check_output("rst_wfifo_empty", wfifo_empty, 1);
      check_output("rst_cpu_valid", cpu_valid, 0);
      check_output("rst_cpu_q", cpu_q, 0);
      check_output("rst_err_drop", err_drop, 0);
      repeat (2) @(negedge clk);
      init_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, expected to finish", $time);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n0;
      do_reset(1'b0);

      $display("[TB] T1 single posted write");
      ack_min = 5;
      ack_max = 5;
      n0 = n_req;
      apply_stimulus(1'b1, 1'b0, 24'h000101, 8'hA5);
      wait_quiet(50);
      settle();
      check_output("T1 port_we", rsp_we, 1);
      check_output("T1 port_a", 32'(rsp_a), 32'h000080);
      check_output("T1 port_ds", 32'(rsp_ds), 32'h2);
      check_output("T1 port_d", 32'(rsp_d), 32'hA5A5);
      check_output("T1 req_toggles", n_req - n0, 1);
      check_output("T1 ctrl_word", 32'(rd_word(23'h000080)), 32'hA500);

      $display("[TB] T2 byte lane reads");
      ack_min = 0;
      ack_max = 3;
      ctrl_mem[int'(23'h000080)] = 16'h1234;
      byte_mem[int'(24'h000100)] = 8'h34;
      byte_mem[int'(24'h000101)] = 8'h12;
      apply_stimulus(1'b0, 1'b1, 24'h000100, 8'h00);
      wait_quiet(50);
      settle();
      check_output("T2 lower_byte", cpu_q, 8'h34);
      apply_stimulus(1'b0, 1'b1, 24'h000101, 8'h00);
      wait_quiet(50);
      settle();
      check_output("T2 upper_byte", cpu_q, 8'h12);

      $display("[TB] T3 queue fills with ack held off");
      hold_ack = 1'b1;
      for (int i = 0; i < 5; i++)
         apply_stimulus(1'b1, 1'b0, 24'h000200 + AW'(i), 8'h50 + 8'(i));
      settle();
      check_output("T3 busy_when_full", cpu_busy, 1);
      check_output("T3 err_drop", err_drop, 1);
      check_output("T3 queued_writes", wr_out, 4);
      n0 = n_wdone;
      hold_ack = 1'b0;
      wait_quiet(80);
      settle();
      check_output("T3 writes_done", n_wdone - n0, 4);
      check_output("T3 ctrl_word", 32'(rd_word(23'h000101)), 32'h5352);

      $display("[TB] T4 write and read in the same cycle");
      apply_stimulus(1'b1, 1'b1, 24'h000010, 8'h5C);
      wait_quiet(50);
      settle();
      check_output("T4 read_new_byte", cpu_q, 8'h5C);

      $display("[TB] T6 reset during an outstanding read");
      hold_ack = 1'b1;
      apply_stimulus(1'b0, 1'b1, 24'h000100, 8'h00);
      begin
         int i = 0;
         while (!rsp_active && i < 20) begin
            idle(1);
            i++;
         end
         check_output("T6 read_issued", rsp_active, 1);
      end
      do_reset(port_bus.ack);
      apply_stimulus(1'b0, 1'b1, 24'h000101, 8'h00);
      wait_quiet(50);
      settle();
      check_output("T6 read_after_reset", cpu_q, 8'h12);

      $display("[TB] T5 adopt ack phase after reset");
      do_reset(1'b1);
      #4;
      check_output("T5 req_in_sync", port_bus.req, 0);
      n0 = n_req;
      @(negedge clk);
      #4;
      check_output("T5 req_adopted", port_bus.req, 1);
      check_output("T5 no_sync_request", n_req - n0, 0);
      apply_stimulus(1'b1, 1'b0, 24'h000020, 8'h3C);
      wait_quiet(50);
      settle();
      check_output("T5 first_req_value", rsp_req, 0);
      check_output("T5 one_request", n_req - n0, 1);

      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         int r;
         r = $urandom_range(99, 0);
         if (exp_busy() && $urandom_range(9, 0) != 0)
            idle(1);
         else if (r < 40)
            apply_stimulus(1'b1, 1'b0, 24'h000300 + AW'($urandom_range(15, 0)), 8'($urandom));
         else if (r < 65)
            apply_stimulus(1'b0, 1'b1, 24'h000300 + AW'($urandom_range(15, 0)), 8'h00);
         else if (r < 72)
            apply_stimulus(1'b1, 1'b1, 24'h000300 + AW'($urandom_range(15, 0)), 8'($urandom));
         else
            idle(1);
      end
      wait_quiet(200);
      settle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
